peripheral_spram_axi4_master: RTL and testbench



---
 rtl/peripheral_spram_axi4_master.sv | 274 +++++++++++++++++++++++++++
 tb/tb_peripheral_spram_axi4_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_spram_axi4_master.sv
// -----------------------------------------------------------------------------
// peripheral_spram_axi4_master
//
// AXI4 initiator behind a native single-port SRAM request port. Each granted
// native request becomes exactly one single-beat AXI4 transaction, with at
// most one transaction outstanding. Completion of reads and writes is signalled
// by a one-cycle rvalid_o pulse.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_i/we_i/addr_i/be_i/data_i   native request (held until gnt_o)
//   gnt_o                   request accepted (combinational)
//   rvalid_o/rdata_o/err_o  completion pulse, read data (held), error flag
//   axi_aw_* / axi_w_* / axi_b_*    AXI4 write channels
//   axi_ar_* / axi_r_*              AXI4 read channels
//
// Build option:
//   PERIPHERAL_SPRAM_AXI4_MASTER_ERR_EN  when defined, err_o reports bit 1 of
//   the B/R response captured at each completion; otherwise err_o is 0.
// -----------------------------------------------------------------------------
module peripheral_spram_axi4_master #(
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_STRB_WIDTH = 8,
    parameter int AXI_USER_WIDTH = 10,
    parameter int TXN_ID         = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
    input  logic [AXI_STRB_WIDTH-1:0] be_i,
    input  logic [AXI_DATA_WIDTH-1:0] data_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
    output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
    output logic [7:0]                axi_aw_len,
    output logic [2:0]                axi_aw_size,
    output logic [1:0]                axi_aw_burst,
    output logic                      axi_aw_lock,
    output logic [3:0]                axi_aw_cache,
    output logic [2:0]                axi_aw_prot,
    output logic [3:0]                axi_aw_qos,
    output logic [3:0]                axi_aw_region,
    output logic [AXI_USER_WIDTH-1:0] axi_aw_user,
    output logic                      axi_aw_valid,
    input  logic                      axi_aw_ready,
    output logic [AXI_DATA_WIDTH-1:0] axi_w_data,
    output logic [AXI_STRB_WIDTH-1:0] axi_w_strb,
    output logic                      axi_w_last,
    output logic [AXI_USER_WIDTH-1:0] axi_w_user,
    output logic                      axi_w_valid,
    input  logic                      axi_w_ready,
    input  logic [AXI_ID_WIDTH-1:0]   axi_b_id,
    input  logic [1:0]                axi_b_resp,
    input  logic [AXI_USER_WIDTH-1:0] axi_b_user,
    input  logic                      axi_b_valid,
    output logic                      axi_b_ready,
    output logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
    output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
    output logic [7:0]                axi_ar_len,
    output logic [2:0]                axi_ar_size,
    output logic [1:0]                axi_ar_burst,
    output logic                      axi_ar_lock,
    output logic [3:0]                axi_ar_cache,
    output logic [2:0]                axi_ar_prot,
    output logic [3:0]                axi_ar_qos,
    output logic [3:0]                axi_ar_region,
    output logic [AXI_USER_WIDTH-1:0] axi_ar_user,
    output logic                      axi_ar_valid,
    input  logic                      axi_ar_ready,
    input  logic [AXI_ID_WIDTH-1:0]   axi_r_id,
    input  logic [AXI_DATA_WIDTH-1:0] axi_r_data,
    input  logic [1:0]                axi_r_resp,
    input  logic                      axi_r_last,
    input  logic [AXI_USER_WIDTH-1:0] axi_r_user,
    input  logic                      axi_r_valid,
    output logic                      axi_r_ready
);

    localparam logic [2:0] AXI_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4
    } state_t;

    state_t                    r_state;
    logic                      r_aw_valid;
    logic                      r_w_valid;
    logic                      r_aw_done;
    logic                      r_w_done;
    logic                      r_b_ready;
    logic                      r_ar_valid;
    logic                      r_r_ready;
    logic                      r_rvalid;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [AXI_STRB_WIDTH-1:0] r_be;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_r_hs;
    logic w_aw_fin;
    logic w_w_fin;

    assign w_aw_hs  = r_aw_valid && axi_aw_ready;
    assign w_w_hs   = r_w_valid && axi_w_ready;
    assign w_b_hs   = r_b_ready && axi_b_valid;
    assign w_r_hs   = r_r_ready && axi_r_valid;
    // A channel counts as finished if it completed earlier or completes now.
    assign w_aw_fin = r_aw_done || w_aw_hs;
    assign w_w_fin  = r_w_done || w_w_hs;

    // Reset is folded in so gnt_o reads 0 while reset is held.
    assign gnt_o    = req_i && (r_state == ST_IDLE) && !rst_i;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;

    assign axi_aw_id     = AXI_ID_WIDTH'(TXN_ID);
    assign axi_aw_addr   = r_addr;
    assign axi_aw_len    = 8'd0;
    assign axi_aw_size   = AXI_SIZE;
    assign axi_aw_burst  = 2'b01;
    assign axi_aw_lock   = 1'b0;
    assign axi_aw_cache  = 4'b0011;
    assign axi_aw_prot   = 3'b000;
    assign axi_aw_qos    = 4'b0000;
    assign axi_aw_region = 4'b0000;
    assign axi_aw_user   = {AXI_USER_WIDTH{1'b0}};
    assign axi_aw_valid  = r_aw_valid;
    assign axi_w_data    = r_wdata;
    assign axi_w_strb    = r_be;
    assign axi_w_last    = 1'b1;
    assign axi_w_user    = {AXI_USER_WIDTH{1'b0}};
    assign axi_w_valid   = r_w_valid;
    assign axi_b_ready   = r_b_ready;
    assign axi_ar_id     = AXI_ID_WIDTH'(TXN_ID);
    assign axi_ar_addr   = r_addr;
    assign axi_ar_len    = 8'd0;
    assign axi_ar_size   = AXI_SIZE;
    assign axi_ar_burst  = 2'b01;
    assign axi_ar_lock   = 1'b0;
    assign axi_ar_cache  = 4'b0011;
    assign axi_ar_prot   = 3'b000;
    assign axi_ar_qos    = 4'b0000;
    assign axi_ar_region = 4'b0000;
    assign axi_ar_user   = {AXI_USER_WIDTH{1'b0}};
    assign axi_ar_valid  = r_ar_valid;
    assign axi_r_ready   = r_r_ready;

    // Single-beat response side-band fields carry nothing this initiator needs.
    logic w_unused_sideband;
    assign w_unused_sideband = ^{axi_b_id, axi_b_user, axi_r_id, axi_r_last, axi_r_user};

    // Transaction FSM: request latch, AXI valids/readies and completion pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_b_ready  <= 1'b0;
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_addr     <= {AXI_ADDR_WIDTH{1'b0}};
            r_be       <= {AXI_STRB_WIDTH{1'b0}};
            r_wdata    <= {AXI_DATA_WIDTH{1'b0}};
            r_rdata    <= {AXI_DATA_WIDTH{1'b0}};
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_i) begin
                        r_addr    <= addr_i;
                        r_be      <= be_i;
                        r_wdata   <= data_i;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (we_i) begin
                            r_aw_valid <= 1'b1;
                            r_w_valid  <= 1'b1;
                            r_state    <= ST_WR_REQ;
                        end else begin
                            r_ar_valid <= 1'b1;
                            r_state    <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    // AW and W retire independently, in either order.
                    if (w_aw_hs) begin
                        r_aw_valid <= 1'b0;
                        r_aw_done  <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_valid <= 1'b0;
                        r_w_done  <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_b_ready <= 1'b1;
                        r_state   <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (w_b_hs) begin
                        r_b_ready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    if (axi_ar_ready) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_state    <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (w_r_hs) begin
                        r_r_ready <= 1'b0;
                        r_rdata   <= axi_r_data;
                        r_rvalid  <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_aw_valid <= 1'b0;
                    r_w_valid  <= 1'b0;
                    r_b_ready  <= 1'b0;
                    r_ar_valid <= 1'b0;
                    r_r_ready  <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PERIPHERAL_SPRAM_AXI4_MASTER_ERR_EN
    logic r_err;

    // Error flag: resp bit 1 (SLVERR/DECERR) of the completing response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_b_hs) begin
            r_err <= axi_b_resp[1];
        end else if (w_r_hs) begin
            r_err <= axi_r_resp[1];
        end else begin
            r_err <= r_err;
        end
    end

    assign err_o = r_err;
`else
    logic w_unused_resp;
    assign w_unused_resp = ^{axi_b_resp, axi_r_resp};
    assign err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_peripheral_spram_axi4_master.sv
module tb_peripheral_spram_axi4_master;

`ifdef PERIPHERAL_SPRAM_AXI4_MASTER_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [63:0] addr_i = 64'd0;
    logic [7:0]  be_i = 8'd0;
    logic [63:0] data_i = 64'd0;
    logic        gnt_o, rvalid_o, err_o;
    logic [63:0] rdata_o;
    logic [9:0]  axi_aw_id, axi_ar_id, axi_aw_user, axi_ar_user, axi_w_user;
    logic [63:0] axi_aw_addr, axi_ar_addr, axi_w_data;
    logic [7:0]  axi_aw_len, axi_ar_len, axi_w_strb;
    logic [2:0]  axi_aw_size, axi_ar_size, axi_aw_prot, axi_ar_prot;
    logic [1:0]  axi_aw_burst, axi_ar_burst;
    logic        axi_aw_lock, axi_ar_lock, axi_aw_valid, axi_ar_valid, axi_w_last, axi_w_valid;
    logic [3:0]  axi_aw_cache, axi_ar_cache, axi_aw_qos, axi_ar_qos, axi_aw_region, axi_ar_region;
    logic        axi_b_ready, axi_r_ready;
    logic        axi_aw_ready = 1'b0, axi_w_ready = 1'b0, axi_ar_ready = 1'b0;
    logic [9:0]  axi_b_id = 10'd0, axi_b_user = 10'd0, axi_r_id = 10'd0, axi_r_user = 10'd0;
    logic [1:0]  axi_b_resp = 2'd0, axi_r_resp = 2'd0;
    logic        axi_b_valid = 1'b0, axi_r_valid = 1'b0, axi_r_last = 1'b0;
    logic [63:0] axi_r_data = 64'd0;

    always #5 clk_i = ~clk_i;

    peripheral_spram_axi4_master dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .be_i(be_i), .data_i(data_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o),
        .axi_aw_id(axi_aw_id), .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len),
        .axi_aw_size(axi_aw_size), .axi_aw_burst(axi_aw_burst), .axi_aw_lock(axi_aw_lock),
        .axi_aw_cache(axi_aw_cache), .axi_aw_prot(axi_aw_prot), .axi_aw_qos(axi_aw_qos),
        .axi_aw_region(axi_aw_region), .axi_aw_user(axi_aw_user), .axi_aw_valid(axi_aw_valid),
        .axi_aw_ready(axi_aw_ready),
        .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
        .axi_w_user(axi_w_user), .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
        .axi_b_id(axi_b_id), .axi_b_resp(axi_b_resp), .axi_b_user(axi_b_user),
        .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready),
        .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len),
        .axi_ar_size(axi_ar_size), .axi_ar_burst(axi_ar_burst), .axi_ar_lock(axi_ar_lock),
        .axi_ar_cache(axi_ar_cache), .axi_ar_prot(axi_ar_prot), .axi_ar_qos(axi_ar_qos),
        .axi_ar_region(axi_ar_region), .axi_ar_user(axi_ar_user), .axi_ar_valid(axi_ar_valid),
        .axi_ar_ready(axi_ar_ready),
        .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
        .axi_r_last(axi_r_last), .axi_r_user(axi_r_user), .axi_r_valid(axi_r_valid),
        .axi_r_ready(axi_r_ready)
    );

    // One native request plus the slave's behaviour for it and what must come back.
    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
        int          a_dly;   // cycles of AW/AR valid before ready
        int          w_dly;   // cycles of W valid before ready
        int          x_dly;   // cycles of B/R wait before response valid
        logic [63:0] rdat;
        logic [1:0]  resp;
        int          gap;     // cycles after previous grant before req rises
        int          exp_lat; // grant cycle to rvalid cycle
        logic [63:0] exp_rdata;
        logic        exp_err;
        bit          tbl;     // exp_rdata/exp_err hold hand-written values
    } txn_t;

    int n_chk = 0;
    int n_err = 0;
    txn_t txq[$];
    txn_t tbl[10];

    // Reference model: what the initiator owes the outside world.
    txn_t        act;
    bit          busy, aw_pend, w_pend, ar_pend, wr_req, b_wait, r_wait, exp_rv;
    int          aw_cnt, w_cnt, ar_cnt, x_cnt;
    logic [63:0] m_rdata;
    logic        m_err;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
        end
    endfunction

    function automatic txn_t mk(input logic we, input logic [63:0] addr, input logic [7:0] be,
                                input logic [63:0] data, input int a, input int w, input int x,
                                input logic [63:0] rdat, input logic [1:0] resp, input int gap,
                                input int lat, input logic [63:0] erd, input logic eerr, input bit t);
        txn_t r;
        r.we = we; r.addr = addr; r.be = be; r.data = data; r.a_dly = a; r.w_dly = w;
        r.x_dly = x; r.rdat = rdat; r.resp = resp; r.gap = gap; r.exp_lat = lat;
        r.exp_rdata = erd; r.exp_err = eerr; r.tbl = t;
        return r;
    endfunction

    task automatic model_clear();
        busy = 0; aw_pend = 0; w_pend = 0; ar_pend = 0; wr_req = 0; b_wait = 0; r_wait = 0;
        exp_rv = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; x_cnt = 0;
        m_rdata = 64'd0; m_err = 1'b0;
    endtask

    // Applies txq back to back, acting as requester and AXI slave, checking every cycle.
    task automatic run_seq(input int maxc, input bit must_finish);
        int n, nxt, done, gap_cnt, grant_cyc;
        bit req_pend, g;
        n = txq.size(); nxt = 0; done = 0; gap_cnt = 0; grant_cyc = 0; req_pend = 0;
        for (int cyc = 0; cyc < maxc && done < n; cyc++) begin
            @(negedge clk_i);
            if (!req_pend && nxt < n) begin
                if (gap_cnt >= txq[nxt].gap) req_pend = 1;
                else gap_cnt++;
            end
            if (req_pend) begin
                req_i = 1'b1; we_i = txq[nxt].we; addr_i = txq[nxt].addr;
                be_i = txq[nxt].be; data_i = txq[nxt].data;
            end else begin
                req_i = 1'b0; we_i = 1'($urandom); addr_i = {$urandom, $urandom};
                be_i = 8'($urandom); data_i = {$urandom, $urandom};
            end
            axi_aw_ready = (aw_cnt >= act.a_dly);
            axi_w_ready  = (w_cnt >= act.w_dly);
            axi_ar_ready = (ar_cnt >= act.a_dly);
            axi_b_valid  = b_wait && (x_cnt >= act.x_dly);
            axi_r_valid  = r_wait && (x_cnt >= act.x_dly);
            axi_b_resp   = axi_b_valid ? act.resp : 2'($urandom);
            axi_r_resp   = axi_r_valid ? act.resp : 2'($urandom);
            axi_r_data   = axi_r_valid ? act.rdat : {$urandom, $urandom};
            axi_b_id = 10'($urandom); axi_r_id = 10'($urandom); axi_r_last = 1'($urandom);
            axi_b_user = 10'($urandom); axi_r_user = 10'($urandom);
            #1;
            g = req_i && !busy;
            chk("gnt", {63'd0, gnt_o}, {63'd0, g});
            chk("rvalid", {63'd0, rvalid_o}, {63'd0, exp_rv});
            chk("rdata", rdata_o, m_rdata);
            chk("err", {63'd0, err_o}, {63'd0, m_err});
            chk("aw_valid", {63'd0, axi_aw_valid}, {63'd0, aw_pend});
            chk("w_valid", {63'd0, axi_w_valid}, {63'd0, w_pend});
            chk("ar_valid", {63'd0, axi_ar_valid}, {63'd0, ar_pend});
            chk("b_ready", {63'd0, axi_b_ready}, {63'd0, b_wait});
            chk("r_ready", {63'd0, axi_r_ready}, {63'd0, r_wait});
            if (aw_pend) begin
                chk("aw_addr", axi_aw_addr, act.addr);
                chk("aw_fields", {15'd0, axi_aw_len, axi_aw_size, axi_aw_burst, axi_aw_id,
                    axi_aw_cache, axi_aw_lock, axi_aw_prot, axi_aw_qos, axi_aw_region, axi_aw_user},
                    {15'd0, 8'd0, 3'd3, 2'b01, 10'd0, 4'b0011, 1'b0, 3'd0, 4'd0, 4'd0, 10'd0});
            end
            if (w_pend) begin
                chk("w_data", axi_w_data, act.data);
                chk("w_strb_last", {44'd0, axi_w_strb, axi_w_last, axi_w_user},
                    {44'd0, act.be, 1'b1, 10'd0});
            end
            if (ar_pend) begin
                chk("ar_addr", axi_ar_addr, act.addr);
                chk("ar_fields", {15'd0, axi_ar_len, axi_ar_size, axi_ar_burst, axi_ar_id,
                    axi_ar_cache, axi_ar_lock, axi_ar_prot, axi_ar_qos, axi_ar_region, axi_ar_user},
                    {15'd0, 8'd0, 3'd3, 2'b01, 10'd0, 4'b0011, 1'b0, 3'd0, 4'd0, 4'd0, 10'd0});
            end
            if (exp_rv) begin
                done++;
                chk("latency", 64'(cyc - grant_cyc), 64'(act.exp_lat));
                if (act.tbl) begin
                    chk("tbl_rdata", rdata_o, act.exp_rdata);
                    chk("tbl_err", {63'd0, err_o}, {63'd0, act.exp_err});
                end
            end
            // Advance the model across the coming clock edge.
            exp_rv = 0;
            if (b_wait && axi_b_valid) begin
                b_wait = 0; busy = 0; exp_rv = 1; m_err = ERR_ON && act.resp[1];
            end else if (r_wait && axi_r_valid) begin
                r_wait = 0; busy = 0; exp_rv = 1; m_err = ERR_ON && act.resp[1];
                m_rdata = act.rdat;
            end else if (b_wait || r_wait) begin
                x_cnt++;
            end
            if (aw_pend) begin if (axi_aw_ready) aw_pend = 0; else aw_cnt++; end
            if (w_pend) begin if (axi_w_ready) w_pend = 0; else w_cnt++; end
            if (ar_pend) begin
                if (axi_ar_ready) begin ar_pend = 0; r_wait = 1; x_cnt = 0; end
                else ar_cnt++;
            end
            if (wr_req && !aw_pend && !w_pend) begin wr_req = 0; b_wait = 1; x_cnt = 0; end
            if (g) begin
                act = txq[nxt]; busy = 1; nxt++; req_pend = 0; gap_cnt = 0; grant_cyc = cyc;
                aw_pend = act.we; w_pend = act.we; wr_req = act.we; ar_pend = !act.we;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; x_cnt = 0;
            end
        end
        if (must_finish) chk("seq_done", 64'(done), 64'(n));
    endtask

    // Raise reset asynchronously mid-cycle, check the cleared outputs at once.
    task automatic reset_check();
        #2;
        rst_i = 1'b1; req_i = 1'b1;
        #1;
        chk("rst_gnt", {63'd0, gnt_o}, 64'd0);
        chk("rst_valids", {58'd0, axi_aw_valid, axi_w_valid, axi_ar_valid, axi_b_ready,
            axi_r_ready, rvalid_o}, 64'd0);
        chk("rst_rdata", rdata_o, 64'd0);
        chk("rst_err", {63'd0, err_o}, 64'd0);
        model_clear();
        @(negedge clk_i);
        rst_i = 1'b0; req_i = 1'b0;
    endtask

    initial begin
        txn_t t;
        int a, w, x;
        model_clear();
        act = mk(1'b0, 64'd0, 8'd0, 64'd0, 0, 0, 0, 64'd0, 2'd0, 0, -1, 64'd0, 1'b0, 1'b0);
        tbl[0] = mk(1'b1, 64'h100, 8'hFF, 64'hDEADBEEF_CAFEF00D, 0, 0, 0, 64'd0, 2'b00,
                    0, 3, 64'd0, 1'b0, 1'b1);
        tbl[1] = mk(1'b0, 64'h100, 8'h00, 64'd0, 0, 0, 0, 64'h12345678_9ABCDEF0, 2'b00,
                    6, 3, 64'h12345678_9ABCDEF0, 1'b0, 1'b1);
        tbl[2] = mk(1'b1, 64'h208, 8'h0F, 64'h01020304_05060708, 3, 0, 0, 64'd0, 2'b00,
                    5, 6, 64'h12345678_9ABCDEF0, 1'b0, 1'b1);
        tbl[3] = mk(1'b0, 64'h310, 8'h00, 64'd0, 0, 0, 5, 64'hAAAABBBB_CCCCDDDD, 2'b00,
                    8, 8, 64'hAAAABBBB_CCCCDDDD, 1'b0, 1'b1);
        tbl[4] = mk(1'b1, 64'h418, 8'h81, 64'h11112222_33334444, 0, 2, 1, 64'd0, 2'b00,
                    0, 6, 64'hAAAABBBB_CCCCDDDD, 1'b0, 1'b1);
        tbl[5] = mk(1'b1, 64'h520, 8'hF0, 64'h99998888_77776666, 1, 1, 0, 64'd0, 2'b10,
                    0, 4, 64'hAAAABBBB_CCCCDDDD, ERR_ON, 1'b1);
        tbl[6] = mk(1'b0, 64'h628, 8'h00, 64'd0, 2, 0, 1, 64'h55556666_77778888, 2'b00,
                    0, 6, 64'h55556666_77778888, 1'b0, 1'b1);
        tbl[7] = mk(1'b1, 64'h730, 8'h3C, 64'hCAFE0000_BEEF1111, 0, 3, 0, 64'd0, 2'b00,
                    0, 6, 64'h55556666_77778888, 1'b0, 1'b1);
        tbl[8] = mk(1'b0, 64'h838, 8'h00, 64'd0, 0, 0, 0, 64'h0F0F0F0F_F0F0F0F0, 2'b11,
                    0, 3, 64'h0F0F0F0F_F0F0F0F0, ERR_ON, 1'b1);
        tbl[9] = mk(1'b0, 64'h940, 8'h00, 64'd0, 0, 0, 1, 64'h0BAD_F00D_0000_0001, 2'b00,
                    4, 4, 64'h0BAD_F00D_0000_0001, 1'b0, 1'b1);

        @(negedge clk_i);
        reset_check();

        // Directed table, applied back to back.
        txq.delete();
        for (int i = 0; i < 10; i++) txq.push_back(tbl[i]);
        run_seq(400, 1'b1);

        // Reset while AR is waiting for ready, then a clean write and read.
        txq.delete();
        txq.push_back(mk(1'b0, 64'hA00, 8'h00, 64'd0, 40, 0, 0, 64'h77, 2'b00, 0, -1,
                         64'd0, 1'b0, 1'b0));
        run_seq(4, 1'b0);
        chk("ar_valid_before_rst", {63'd0, axi_ar_valid}, 64'd1);
        reset_check();
        txq.delete();
        txq.push_back(mk(1'b1, 64'hB00, 8'hFF, 64'h1357_9BDF_2468_ACE0, 0, 0, 0, 64'd0, 2'b00,
                         1, 3, 64'd0, 1'b0, 1'b1));
        txq.push_back(mk(1'b0, 64'hB00, 8'h00, 64'd0, 1, 0, 2, 64'h1357_9BDF_2468_ACE0, 2'b00,
                         0, 6, 64'h1357_9BDF_2468_ACE0, 1'b0, 1'b1));
        run_seq(100, 1'b1);

        // Randomized traffic against the model.
        txq.delete();
        for (int i = 0; i < 60; i++) begin
            a = int'($urandom_range(0, 4)); w = int'($urandom_range(0, 4));
            x = int'($urandom_range(0, 4));
            t = mk(1'($urandom), {$urandom, $urandom}, 8'($urandom), {$urandom, $urandom},
                   a, w, x, {$urandom, $urandom}, 2'($urandom), int'($urandom_range(0, 8)),
                   0, 64'd0, 1'b0, 1'b0);
            t.exp_lat = t.we ? (3 + ((a > w) ? a : w) + x) : (3 + a + x);
            txq.push_back(t);
        end
        run_seq(3000, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
